button_press_classifier: RTL and testbench

- Downstream consumer of the debounced push-button level produced by the button-debounce stage.
- Runs in the same divided clock domain (clk_169344, ~200 Hz / 5 ms tick), so no input synchroniser is needed.
- Classifies each press as short or long, and optionally generates auto-repeat pulses while held.
- Emits single-cycle event pulses and a short-press counter for the control/UI logic.

---
 rtl/button_press_classifier_pkg.sv | 25 ++
 rtl/button_press_classifier_if.sv | 24 ++
 rtl/button_press_classifier_tick_counter.sv | 34 +++
 rtl/button_press_classifier.sv | 143 ++++++++++++++
 tb/tb_button_press_classifier.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/button_press_classifier_pkg.sv
// Shared types and defaults for the push-button classifier and sibling UI blocks.
// Holds the classifier state encoding, default tick counts and event pulse bundle.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam int LONG_TICKS_DEF   = 200;
    localparam int REPEAT_TICKS_DEF = 40;
    localparam int PRESS_COUNT_W    = 8;

    // One bit per single-cycle event; all fields pulse for exactly one tick.
    typedef struct packed {
        logic short_press;
        logic long_press;
        logic release_evt;
        logic repeat_evt;
    } btn_evt_t;

    localparam btn_evt_t EVT_NONE = '{default: 1'b0};

endpackage

// File: rtl/button_press_classifier_if.sv
// Bundle between the debounced button source and the classifier's event consumers.
// The classifier connects through the slave modport; the source/UI side uses master.
interface button_press_classifier_if;
    import btn_pkg::*;

    logic                     btn_deb;
    logic                     btn_held;
    logic                     short_press;
    logic                     long_press;
    logic                     release_evt;
    logic                     repeat_evt;
    logic [PRESS_COUNT_W-1:0] press_count;

    modport master (
        output btn_deb,
        input  btn_held, short_press, long_press, release_evt, repeat_evt, press_count
    );

    modport slave (
        input  btn_deb,
        output btn_held, short_press, long_press, release_evt, repeat_evt, press_count
    );

endinterface

// File: rtl/button_press_classifier_tick_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over enable).
// Used for the hold-length counter and the auto-repeat interval counter.
module btn_tick_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_Q = W'(MAX);
    localparam logic [W-1:0] ONE_Q = W'(1);

    logic [W-1:0] count_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != MAX_Q)) begin
            count_r <= count_r + ONE_Q;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short/long and emits registered event pulses.
// Auto-repeat while long-held is built only when BTN_AUTOREPEAT_EN is defined.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter  int LONG_TICKS   = LONG_TICKS_DEF,
    parameter  int REPEAT_TICKS = REPEAT_TICKS_DEF,
    localparam int CNT_W        = $clog2(LONG_TICKS + 1)
) (
    input  logic                      clk_169344,
    input  logic                      rst,
    button_press_classifier_if.slave  bus
);

    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(LONG_TICKS - 1);
    localparam logic [PRESS_COUNT_W-1:0] COUNT_ONE = PRESS_COUNT_W'(1);

    if ((LONG_TICKS < 2) || (REPEAT_TICKS < 1)) begin : g_param_check
        $error("button_press_classifier: LONG_TICKS must be >= 2 and REPEAT_TICKS >= 1");
    end

    state_t                   state_r;
    state_t                   state_s;
    logic                     btn_q_r;
    logic                     held_r;
    btn_evt_t                 evt_r;
    btn_evt_t                 evt_s;
    logic [PRESS_COUNT_W-1:0] press_count_r;
    logic [CNT_W-1:0]         cnt_s;
    logic                     cnt_clr_s;
    logic                     cnt_en_s;
    logic                     rep_hit_s;

    btn_tick_counter #(
        .W   (CNT_W),
        .MAX (LONG_TICKS - 1)
    ) u_hold_cnt (
        .clk   (clk_169344),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0] rep_cnt_s;
    logic             rep_clr_s;
    logic             rep_en_s;

    // Interval counter restarts after each repeat pulse and whenever not long-held.
    always_comb begin
        rep_hit_s = (state_r == LONG) && bus.btn_deb && (rep_cnt_s == REP_LAST);
        rep_clr_s = !((state_r == LONG) && bus.btn_deb) || rep_hit_s;
        rep_en_s  = !rep_clr_s;
    end

    btn_tick_counter #(
        .W   (REP_W),
        .MAX (REPEAT_TICKS - 1)
    ) u_repeat_cnt (
        .clk   (clk_169344),
        .rst   (rst),
        .clr   (rep_clr_s),
        .en    (rep_en_s),
        .count (rep_cnt_s)
    );
`else
    assign rep_hit_s = 1'b0;
`endif

    // Next-state and event decode; a release in PRESS beats the long threshold.
    always_comb begin
        state_s             = state_r;
        evt_s               = EVT_NONE;
        evt_s.repeat_evt    = rep_hit_s;
        cnt_clr_s           = (state_r != PRESS);
        cnt_en_s            = (state_r == PRESS) && bus.btn_deb;
        case (state_r)
            IDLE: begin
                if (bus.btn_deb && !btn_q_r) begin
                    state_s = PRESS;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS: begin
                if (!bus.btn_deb) begin
                    state_s           = IDLE;
                    evt_s.short_press = 1'b1;
                    evt_s.release_evt = 1'b1;
                end else if (cnt_s == CNT_LAST) begin
                    state_s          = LONG;
                    evt_s.long_press = 1'b1;
                end else begin
                    state_s = PRESS;
                end
            end
            LONG: begin
                if (!bus.btn_deb) begin
                    state_s           = IDLE;
                    evt_s.release_evt = 1'b1;
                end else begin
                    state_s = LONG;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, previous-sample and registered outputs; btn_q resets high to ignore a held button.
    always_ff @(posedge clk_169344 or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            btn_q_r       <= 1'b1;
            held_r        <= 1'b0;
            evt_r         <= EVT_NONE;
            press_count_r <= '0;
        end else begin
            state_r <= state_s;
            btn_q_r <= bus.btn_deb;
            held_r  <= (state_s != IDLE);
            evt_r   <= evt_s;
            if (evt_s.short_press) begin
                press_count_r <= press_count_r + COUNT_ONE;
            end else begin
                press_count_r <= press_count_r;
            end
        end
    end

    assign bus.btn_held    = held_r;
    assign bus.short_press = evt_r.short_press;
    assign bus.long_press  = evt_r.long_press;
    assign bus.release_evt = evt_r.release_evt;
    assign bus.repeat_evt  = evt_r.repeat_evt;
    assign bus.press_count = press_count_r;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_TICKS=10, REPEAT_TICKS=4.
// Repeat expectations follow BTN_AUTOREPEAT_EN as defined for the build.
module tb_button_press_classifier;
    import btn_pkg::*;

    logic clk_169344 = 1'b0;
    logic rst        = 1'b1;

    always #5 clk_169344 = ~clk_169344;

    button_press_classifier_if bus();

    button_press_classifier #(
        .LONG_TICKS   (10),
        .REPEAT_TICKS (4)
    ) dut (
        .clk_169344 (clk_169344),
        .rst        (rst),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int n_short = 0;
    int n_long = 0;
    int n_rel = 0;
    int n_rep = 0;
    int long_edge = -1;
    int width_err = 0;
    int rep_edges[$];
    logic prev_short = 1'b0, prev_long = 1'b0, prev_rel = 1'b0, prev_rep = 1'b0;

    always @(posedge clk_169344) edge_n <= edge_n + 1;

    // Event monitor: counts pulses, records the producing edge, flags pulses wider than one cycle.
    always @(negedge clk_169344) begin
        if (bus.short_press) n_short <= n_short + 1;
        if (bus.long_press) begin
            n_long    <= n_long + 1;
            long_edge <= edge_n;
        end
        if (bus.release_evt) n_rel <= n_rel + 1;
        if (bus.repeat_evt) begin
            n_rep <= n_rep + 1;
            rep_edges.push_back(edge_n);
        end
        if ((bus.short_press && prev_short) || (bus.long_press && prev_long) ||
            (bus.release_evt && prev_rel) || (bus.repeat_evt && prev_rep))
            width_err <= width_err + 1;
        prev_short <= bus.short_press;
        prev_long  <= bus.long_press;
        prev_rel   <= bus.release_evt;
        prev_rep   <= bus.repeat_evt;
    end

    task automatic step();
        @(posedge clk_169344);
        #1;
    endtask

    task automatic clear_counts();
        n_short   = 0;
        n_long    = 0;
        n_rel     = 0;
        n_rep     = 0;
        long_edge = -1;
        rep_edges.delete();
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        bus.btn_deb = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({bus.btn_held, bus.short_press, bus.long_press, bus.release_evt, bus.repeat_evt} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {bus.btn_held, bus.short_press, bus.long_press, bus.release_evt, bus.repeat_evt});
        end
        n_cmp++;
        if (bus.press_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d, expected 0", bus.press_count);
        end
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_short();
        clear_counts();
        n_cmp++;
        if (bus.btn_held !== 1'b0) begin
            n_bad++;
            $display("FAIL short_held_before: got %b, expected 0", bus.btn_held);
        end
        bus.btn_deb = 1'b1;
        step();
        n_cmp++;
        if (bus.btn_held !== 1'b1) begin
            n_bad++;
            $display("FAIL short_held_after_t0: got %b, expected 1", bus.btn_held);
        end
        repeat (2) step();
        bus.btn_deb = 1'b0;
        step();
        n_cmp++;
        if ({bus.short_press, bus.release_evt, bus.btn_held} !== 3'b110) begin
            n_bad++;
            $display("FAIL short_release_edge: got short/rel/held=%b, expected 110",
                     {bus.short_press, bus.release_evt, bus.btn_held});
        end
        chk("short_count_same_edge", int'(bus.press_count), 1);
        repeat (3) step();
        chk("short_n_short", n_short, 1);
        chk("short_n_rel", n_rel, 1);
        chk("short_n_long", n_long, 0);
        chk("short_n_rep", n_rep, 0);
    endtask

    task automatic test_long();
        int t0;
        clear_counts();
        bus.btn_deb = 1'b1;
        t0 = edge_n + 1;
        repeat (15) step();
        bus.btn_deb = 1'b0;
        step();
        n_cmp++;
        if ({bus.short_press, bus.release_evt} !== 2'b01) begin
            n_bad++;
            $display("FAIL long_release_edge: got short/rel=%b, expected 01",
                     {bus.short_press, bus.release_evt});
        end
        repeat (2) step();
        chk("long_n_long", n_long, 1);
        chk("long_edge", long_edge, t0 + 10);
        chk("long_n_short", n_short, 0);
        chk("long_n_rel", n_rel, 1);
        chk("long_count_unchanged", int'(bus.press_count), 1);
    endtask

    task automatic test_boundary();
        clear_counts();
        bus.btn_deb = 1'b1;
        repeat (10) step();
        bus.btn_deb = 1'b0;
        repeat (3) step();
        chk("boundary_n_short", n_short, 1);
        chk("boundary_n_long", n_long, 0);
        chk("boundary_n_rel", n_rel, 1);
        chk("boundary_count", int'(bus.press_count), 2);
    endtask

    task automatic test_autorepeat();
        int t0;
        clear_counts();
        bus.btn_deb = 1'b1;
        t0 = edge_n + 1;
        repeat (22) step();
        bus.btn_deb = 1'b0;
        repeat (3) step();
        chk("autorep_n_long", n_long, 1);
        chk("autorep_n_short", n_short, 0);
`ifdef BTN_AUTOREPEAT_EN
        chk("autorep_n_rep", rep_edges.size(), 2);
        if (rep_edges.size() >= 2) begin
            chk("autorep_first_edge", rep_edges[0], t0 + 14);
            chk("autorep_second_edge", rep_edges[1], t0 + 18);
        end
`else
        chk("autorep_disabled_n_rep", n_rep, 0);
`endif
    endtask

    task automatic test_held_through_reset();
        clear_counts();
        rst = 1'b1;
        bus.btn_deb = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        chk("heldrst_events", n_short + n_long + n_rel + n_rep, 0);
        chk("heldrst_btn_held", int'(bus.btn_held), 0);
        bus.btn_deb = 1'b0;
        repeat (2) step();
        bus.btn_deb = 1'b1;
        repeat (2) step();
        bus.btn_deb = 1'b0;
        repeat (3) step();
        chk("heldrst_n_short", n_short, 1);
        chk("heldrst_n_rel", n_rel, 1);
        chk("heldrst_count", int'(bus.press_count), 1);
    endtask

    task automatic test_mid_reset();
        clear_counts();
        bus.btn_deb = 1'b1;
        repeat (6) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.btn_held, bus.short_press, bus.long_press, bus.release_evt, bus.repeat_evt} !== 5'b00000
            || bus.press_count !== 8'd0) begin
            n_bad++;
            $display("FAIL midrst_immediate: got flags=%b count=%0d, expected 00000 and 0",
                     {bus.btn_held, bus.short_press, bus.long_press, bus.release_evt, bus.repeat_evt},
                     bus.press_count);
        end
        bus.btn_deb = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("midrst_events", n_short + n_long + n_rel + n_rep, 0);
    endtask

    task automatic test_back_to_back_wrap();
        clear_counts();
        for (int i = 0; i < 256; i++) begin
            bus.btn_deb = 1'b1;
            step();
            bus.btn_deb = 1'b0;
            step();
            if (i == 254) chk("wrap_count_255", int'(bus.press_count), 255);
        end
        step();
        chk("wrap_count_0", int'(bus.press_count), 0);
        chk("wrap_n_short", n_short, 256);
        chk("wrap_n_rel", n_rel, 256);
        chk("wrap_n_long", n_long, 0);
    endtask

    initial begin
        bus.btn_deb = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_boundary();
        test_autorepeat();
        test_held_through_reset();
        test_mid_reset();
        test_back_to_back_wrap();
        chk("pulse_width", width_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
